mmio_uart_fifo: RTL
===================

Name: mmio_uart_fifo

Overview:
Memory-mapped UART I/O controller between the core's decode/memory stage and the UART RX/TX byte engines. It replaces the single-register, stall-on-every-byte scheme with parametrised RX and TX FIFOs and a status register. The core stalls only when a data access cannot complete (RX empty on read, TX full on write). Read data is registered and returned one cycle after an accepted read, aligned with the writeback stage.

Parameters:
ADDR_W, 25, width of the data-address bus.
RX_DEPTH, 16, RX FIFO entries (power of two, >=2).
TX_DEPTH, 16, TX FIFO entries (power of two, >=2).
DATA_ADDR, 0, word address of the data register.
STAT_ADDR, 1, word address of the status register.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (rst=0 resets all state)
req_addr  in  ADDR_W  data address from decode
req_re  in  1  load request
req_we  in  1  store request
req_wdata  in  32  store data; bits [7:0] are used for TX
stall  out  1  combinational; holds PC and decode this cycle
rdata  out  32  registered load data
io_hit  out  1  registered; rdata is valid for the writeback mux
rx_byte  in  8  byte from UART RX engine
rx_valid  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  8  byte to UART TX engine
tx_start  out  1  one-cycle launch pulse
tx_ready  in  1  TX engine idle; drops the cycle after tx_start

Behaviour:
- Reset: rdata=0, io_hit=0, tx_start=0, tx_byte=0, FIFOs empty, overflow flag=0, FSM=IDLE.
- Hit: req_addr equals DATA_ADDR or STAT_ADDR. A miss has no effect, never stalls, and gives io_hit=0 next cycle.
- Data read: stall=1 if RX FIFO is empty. Otherwise pop; next cycle rdata={24'b0,head}, io_hit=1.
- Data write: stall=1 if TX FIFO is full (registered full; no bypass through same-cycle drain). Otherwise push req_wdata[7:0].
- A stalled access has no side effect. It is re-evaluated every cycle while the request is held.
- Status read never stalls. Next cycle rdata is: bit0 RX non-empty, bit1 TX not full, bit2 RX overflow, bits[15:8] RX count, bits[23:16] TX count, rest 0.
  - A status read clears the overflow flag. A new overflow in the same cycle wins (flag stays 1).
- Status write: ignored, no stall.
- req_re and req_we together: treated as a read. The write is discarded.
- RX push: on rx_valid when not full. Full and no pop that cycle: byte dropped, overflow flag set. Full with a core pop the same cycle: push accepted and count unchanged.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, pointers wrap modulo depth.
- TX FSM:
  - IDLE: TX non-empty and tx_ready=1 → tx_byte=head, tx_start=1 for one cycle, pop, go to HOLD.
  - HOLD: tx_start=0 for one guard cycle, then IDLE.
  - Maximum rate is one byte per 2 cycles when the engine allows it.
- tx_byte holds its last value between launches.
- Reset asserted mid-operation: all state clears immediately (asynchronous) and queued bytes are lost. A tx_start in flight is cut.

Optional Feature:
MMIO_UART_LOOPBACK_EN. When defined:
- TX launches are also pushed into the RX FIFO.
- rx_byte/rx_valid are ignored; the RX engine is disconnected internally.
- tx_start still pulses, so the line stays observable.
- The loopback push obeys the RX overflow rules.
When undefined: normal external RX path only.

Decomposition:
- Package cpu_io_pkg:
  - DATA_ADDR/STAT_ADDR defaults.
  - Status bit index constants (ST_RX_NE=0, ST_TX_NF=1, ST_OVF=2, count field offsets).
  - TX FSM enum tx_state_t {IDLE, HOLD}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports push, pop, din, dout (show-ahead head), full, empty, count.
  - asynchronous active-low reset.
  - Instantiated twice.

Test Plan:
- Three rx_valid strobes with 0x41, 0x42, 0x43, then three data reads → no stall; rdata sequence 0x41, 0x42, 0x43 with io_hit=1 one cycle after each read.
- Data read with RX empty, rx_valid 0x55 arrives 5 cycles later → stall=1 for exactly those cycles, then rdata=0x55.
- 17 writes 0x00..0x10 with tx_ready held 0 → 17th write stalls. Raise tx_ready → tx_start pulses emit 0x00, 0x01, … in order; stall drops after the first launch.
- 17 rx_valid bytes with no reads → status bit2=1, count=16. A second status read shows bit2=0. Reading the 16 bytes returns the first 16; byte 17 is lost.
- Status read after 2 RX bytes and 3 queued TX bytes → rdata=0x0003_0203 (count fields plus flags RX non-empty, TX not full).
- With MMIO_UART_LOOPBACK_EN: write 0xA5 with tx_ready=1 → tx_start pulse, then a data read returns 0xA5. Also assert rst=0 while 4 TX bytes are queued → tx_start stops and status reads 0x0000_0002 after release.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the MMIO UART FIFO controller.
// Optional build macro: MMIO_UART_LOOPBACK_EN (TX launches feed RX).
package cpu_io_pkg;

  localparam int DATA_ADDR_DEF = 0;
  localparam int STAT_ADDR_DEF = 1;

  localparam int ST_RX_NE = 0;
  localparam int ST_TX_NF = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_RXCNT = 8;
  localparam int ST_TXCNT = 16;
  localparam int ST_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tx_state_t;

  function automatic logic [31:0] pack_status(
    input logic                rx_ne,
    input logic                tx_nf,
    input logic                ovf,
    input logic [ST_CNT_W-1:0] rx_cnt,
    input logic [ST_CNT_W-1:0] tx_cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_RX_NE] = rx_ne;
    s[ST_TX_NF] = tx_nf;
    s[ST_OVF]   = ovf;
    s[ST_RXCNT +: ST_CNT_W] = rx_cnt;
    s[ST_TXCNT +: ST_CNT_W] = tx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only
// when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_fifo.sv
// MMIO UART controller: RX/TX FIFOs, status register, TX launch FSM.
// Build option MMIO_UART_LOOPBACK_EN routes TX launches into RX.
module mmio_uart_fifo
  import cpu_io_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int DATA_ADDR = DATA_ADDR_DEF,
  parameter int STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              io_hit,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_ready
);

  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;

  logic           hit_data, hit_stat;
  logic           rd_data, rd_stat, wr_data;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     rx_dout, tx_dout;
  logic [RCW-1:0] rx_cnt;
  logic [TCW-1:0] tx_cnt;
  logic           src_v;
  logic [7:0]     src_b;
  logic           ovf_set;
  logic [31:0]    status;
  logic           unused_wd;

  logic [31:0] rdata_q, rdata_d;
  logic        io_hit_q, io_hit_d;
  logic        ovf_q, ovf_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  tx_state_t   state_q, state_d;

  assign hit_data = (req_addr == ADDR_W'(DATA_ADDR));
  assign hit_stat = (req_addr == ADDR_W'(STAT_ADDR));
  assign rd_data  = req_re & hit_data;
  assign rd_stat  = req_re & hit_stat;
  assign wr_data  = req_we & ~req_re & hit_data;
  assign unused_wd = ^req_wdata[31:8];

  assign rx_pop  = rd_data & ~rx_empty;
  assign tx_push = wr_data & ~tx_full;
  assign stall   = (rd_data & rx_empty) | (wr_data & tx_full);

`ifdef MMIO_UART_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = ^{rx_byte, rx_valid};
  assign src_v = tx_pop;
  assign src_b = tx_dout;
`else
  assign src_v = rx_valid;
  assign src_b = rx_byte;
`endif

  // A full RX FIFO still accepts a byte when the core drains one now.
  assign rx_push = src_v & (~rx_full | rx_pop);
  assign ovf_set = src_v & rx_full & ~rx_pop;

  assign status = pack_status(~rx_empty, ~tx_full, ovf_q,
                              ST_CNT_W'(rx_cnt), ST_CNT_W'(tx_cnt));

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk   (clk),
    .rst_n (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (src_b),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk   (clk),
    .rst_n (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (req_wdata[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  always_comb begin
    rdata_d  = rdata_q;
    io_hit_d = rx_pop | rd_stat;
    unique case (1'b1)
      rx_pop:  rdata_d = {24'h0, rx_dout};
      rd_stat: rdata_d = status;
      default: ;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (rd_stat) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty && tx_ready) begin
          tx_start_d = 1'b1;
          tx_byte_d  = tx_dout;
          tx_pop     = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q    <= '0;
      io_hit_q   <= 1'b0;
      ovf_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      state_q    <= IDLE;
    end else begin
      rdata_q    <= rdata_d;
      io_hit_q   <= io_hit_d;
      ovf_q      <= ovf_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      state_q    <= state_d;
    end
  end

  assign rdata    = rdata_q;
  assign io_hit   = io_hit_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;

endmodule
